// File: rtl/cnn_mem_pkg.sv
// Shared definitions for the image tile store.
//   state_t    : tile store control states
//   clog2      : ceiling log2, used for parameter checks
//   DATA_W_DEF : default pixel width
package cnn_mem_pkg;

   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_LOAD  = 2'd2,
      ST_FULL  = 2'd3
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/ram_image_bank_if.sv
// Stream-load and read bus of the image tile store.
//   s_valid/s_ready/s_data : pixel stream, one pixel per channel, channel c at [c*DATA_W +: DATA_W]
//   rd_en/raddr            : read request
//   rdata/rvalid           : registered read result, same packing as s_data
// master = producer/consumer side, slave = the tile store.
interface ram_image_bank_if #(
   parameter int NUM_CH = 1,
   parameter int ADDR_W = 4,
   parameter int DATA_W = cnn_mem_pkg::DATA_W_DEF
) ();

   logic                       s_valid;
   logic                       s_ready;
   logic [NUM_CH*DATA_W-1:0]   s_data;
   logic                       rd_en;
   logic [ADDR_W-1:0]          raddr;
   logic [NUM_CH*DATA_W-1:0]   rdata;
   logic                       rvalid;

   modport master (
      output s_valid, s_data, rd_en, raddr,
      input  s_ready, rdata, rvalid
   );

   modport slave (
      input  s_valid, s_data, rd_en, raddr,
      output s_ready, rdata, rvalid
   );

endinterface

// File: rtl/ram_bank_sp.sv
// One channel bank: DEPTH x DATA_W, single write port, registered read-first read port.
//   clk, rst_n : clock, synchronous active-low reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr   : read request; rzero forces the result to zero (out-of-range address)
//   rdata      : read register, updated only on re, holds otherwise
module ram_bank_sp #(
   parameter int DEPTH  = 9,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic              rzero,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage has no reset; the controller zeroes it with a clear sweep.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Non-blocking update gives read-first behaviour on a same-address write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= rzero ? '0 : mem[raddr];
      end
   end

endmodule

// File: rtl/ram_image_bank.sv
// Multi-channel image tile store: NUM_CH banks of DEPTH pixels, loaded through a
// valid/ready stream, zeroed by a hardware clear sweep, read through a registered port.
//   clk, rst_n            : clock, synchronous active-low reset
//   clr_start, load_start : command pulses (clear wins when both are high)
//   busy                  : clear sweep or load in progress
//   loaded                : a complete tile is present
//   bus                   : stream and read port (ram_image_bank_if.slave)
//
// state    | meaning
// ST_CLEAR | writing zero to wptr each cycle, DEPTH cycles, commands ignored
// ST_IDLE  | no valid tile, waiting for clear or load
// ST_LOAD  | accepting stream pixels at wptr, s_ready high
// ST_FULL  | tile complete, waiting for clear or reload
module ram_image_bank
   import cnn_mem_pkg::*;
#(
   parameter int NUM_CH = 1,
   parameter int DEPTH  = 9,
   parameter int ADDR_W = 4,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_start,
   input  logic load_start,
   output logic busy,
   output logic loaded,
   ram_image_bank_if.slave bus
);

   if (clog2(DEPTH) > ADDR_W) begin : g_addr_chk
      $error("ram_image_bank: ADDR_W too narrow for DEPTH");
   end

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t                   state_q, state_d;
   logic [ADDR_W-1:0]        wptr_q, wptr_d;
   logic                     wr_en, wr_zero, bank_we;
   logic                     rd_in_range;
   logic                     rvalid_q;
   logic [DATA_W-1:0]        bank_rdata [NUM_CH];
   logic [NUM_CH*DATA_W-1:0] rdata_pk;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_CLEAR;
         wptr_q   <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wptr_q   <= wptr_d;
         rvalid_q <= bus.rd_en;
      end
   end

   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      wr_en   = 1'b0;
      wr_zero = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            wr_en   = 1'b1;
            wr_zero = 1'b1;
            if (wptr_q == LAST_ADDR) begin
               wptr_d  = '0;
               state_d = ST_IDLE;
            end else begin
               wptr_d = wptr_q + 1'b1;
            end
         end
         ST_IDLE, ST_FULL: begin
            if (clr_start) begin
               state_d = ST_CLEAR;
               wptr_d  = '0;
            end else if (load_start) begin
               state_d = ST_LOAD;
               wptr_d  = '0;
            end
         end
         ST_LOAD: begin
            // An abort discards the partial tile; the pixel offered this cycle is not written.
            if (clr_start) begin
               state_d = ST_CLEAR;
               wptr_d  = '0;
            end else if (bus.s_valid) begin
               wr_en = 1'b1;
               if (wptr_q == LAST_ADDR) begin
                  wptr_d  = '0;
                  state_d = ST_FULL;
               end else begin
                  wptr_d = wptr_q + 1'b1;
               end
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   // No write may land on the edge where reset is sampled.
   assign bank_we     = wr_en && rst_n;
   assign rd_in_range = ({1'b0, bus.raddr} < (ADDR_W+1)'(DEPTH));

   for (genvar c = 0; c < NUM_CH; c++) begin : g_bank
      ram_bank_sp #(
         .DEPTH  (DEPTH),
         .ADDR_W (ADDR_W),
         .DATA_W (DATA_W)
      ) u_bank (
         .clk   (clk),
         .rst_n (rst_n),
         .we    (bank_we),
         .waddr (wptr_q),
         .wdata (wr_zero ? '0 : bus.s_data[c*DATA_W +: DATA_W]),
         .re    (bus.rd_en),
         .rzero (!rd_in_range),
         .raddr (bus.raddr),
         .rdata (bank_rdata[c])
      );
   end

   always_comb begin
      rdata_pk = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         rdata_pk[c*DATA_W +: DATA_W] = bank_rdata[c];
      end
   end

   assign bus.rdata   = rdata_pk;
   assign bus.rvalid  = rvalid_q;
   assign bus.s_ready = (state_q == ST_LOAD);
   assign busy        = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
   assign loaded      = (state_q == ST_FULL);

endmodule

// File: tb/tb_ram_image_bank.sv
module tb_ram_image_bank;
   import cnn_mem_pkg::*;

   localparam int NUM_CH = 2;
   localparam int DEPTH  = 9;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 16;
   localparam int W      = NUM_CH * DATA_W;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [W-1:0]      exp;
   } rd_vec_t;

   logic clk        = 1'b0;
   logic rst_n      = 1'b0;
   logic clr_start  = 1'b0;
   logic load_start = 1'b0;
   logic busy, loaded;

   ram_image_bank_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ram_image_bank #(
      .NUM_CH (NUM_CH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_start  (clr_start),
      .load_start (load_start),
      .busy       (busy),
      .loaded     (loaded),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int          chk_cnt  = 0;
   int          pass_cnt = 0;
   logic [W-1:0] sb [$];
   logic [W-1:0] ref_mem [DEPTH];
   int          wp      = 0;
   logic        in_load = 1'b0;
   rd_vec_t     tbl [12];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else pass_cnt++;
   endtask

   function automatic logic [W-1:0] exp_read(input logic [ADDR_W-1:0] a);
      if (int'(a) < DEPTH) return ref_mem[a];
      return '0;
   endfunction

   task automatic zero_model();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
   endtask

   // One clock; afterwards compare the read strobe and pop the scoreboard.
   task automatic tick();
      logic req;
      logic [W-1:0] e;
      req = bus.rd_en && rst_n;
      @(posedge clk);
      #1;
      check("rvalid", {63'd0, bus.rvalid}, {63'd0, req});
      if (req) begin
         if (sb.size() == 0) begin
            chk_cnt++;
            $display("FAIL scoreboard: got empty queue expected an entry");
         end else begin
            e = sb.pop_front();
            check("rdata", {32'd0, bus.rdata}, {32'd0, e});
         end
      end
   endtask

   task automatic issue(input logic v, input logic [W-1:0] d, input logic r,
                        input logic [ADDR_W-1:0] a, input logic [W-1:0] e, output logic hs);
      check("s_ready", {63'd0, bus.s_ready}, {63'd0, in_load});
      bus.s_valid = v;
      bus.s_data  = d;
      bus.rd_en   = r;
      bus.raddr   = a;
      if (r) sb.push_back(e);
      hs = v && in_load;
      if (hs) begin
         ref_mem[wp] = d;
         wp++;
         if (wp == DEPTH) in_load = 1'b0;
      end
      tick();
      bus.s_valid = 1'b0;
      bus.rd_en   = 1'b0;
   endtask

   task automatic read_all();
      logic hs;
      for (int a = 0; a < DEPTH; a++) issue(1'b0, '0, 1'b1, ADDR_W'(a), exp_read(ADDR_W'(a)), hs);
   endtask

   task automatic wait_clear(output int n);
      n = 0;
      while (busy && n < 30) begin
         n++;
         tick();
      end
   endtask

   task automatic start_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      in_load    = 1'b1;
      wp         = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int   n, k, c;
      logic hs, tog;
      logic [W-1:0] last_rd;

      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.rd_en   = 1'b0;
      bus.raddr   = '0;
      zero_model();
      for (int i = 0; i < DEPTH; i++) begin
         tbl[i].addr = ADDR_W'(i);
         tbl[i].exp  = {16'(16'h1000 + i), 16'(i)};
      end
      tbl[9]  = '{addr: 4'd12, exp: 32'h0};
      tbl[10] = '{addr: 4'd15, exp: 32'h0};
      tbl[11] = '{addr: 4'd4,  exp: 32'h1004_0004};

      // reset and power-up clear sweep
      tick();
      tick();
      check("rst_busy",   {63'd0, busy},       64'd1);
      check("rst_loaded", {63'd0, loaded},     64'd0);
      check("rst_sready", {63'd0, bus.s_ready}, 64'd0);
      check("rst_rdata",  {32'd0, bus.rdata},  64'd0);
      rst_n = 1'b1;
      wait_clear(n);
      check("clear_len", 64'(n), 64'd9);
      check("idle_busy",   {63'd0, busy},   64'd0);
      check("idle_loaded", {63'd0, loaded}, 64'd0);
      read_all();

      // full load, s_valid held high
      start_load();
      for (int i = 0; i < DEPTH; i++) begin
         check("loaded_during_load", {63'd0, loaded}, 64'd0);
         issue(1'b1, {16'(16'h1000 + i), 16'(i)}, 1'b0, '0, '0, hs);
      end
      check("full_loaded", {63'd0, loaded},      64'd1);
      check("full_busy",   {63'd0, busy},        64'd0);
      check("full_sready", {63'd0, bus.s_ready}, 64'd0);
      last_rd = '0;
      for (int i = 0; i < 12; i++) begin
         issue(1'b0, '0, 1'b1, tbl[i].addr, tbl[i].exp, hs);
         last_rd = tbl[i].exp;
      end
      tick();
      check("rdata_hold", {32'd0, bus.rdata}, {32'd0, last_rd});

      // load with s_valid toggling; idle cycles carry junk data
      start_load();
      k = 0; c = 0; tog = 1'b1;
      while (k < DEPTH && c < 60) begin
         if (tog) issue(1'b1, {16'(16'h2000 + k), 16'(16'h0100 + k)}, 1'b0, '0, '0, hs);
         else     issue(1'b0, 32'hDEAD_DEAD, 1'b0, '0, '0, hs);
         if (hs) k++;
         tog = !tog;
         c++;
      end
      check("toggle_hs",     64'(k), 64'd9);
      check("toggle_loaded", {63'd0, loaded}, 64'd1);
      issue(1'b0, '0, 1'b1, 4'd8, 32'h2008_0108, hs);
      read_all();

      // abort after 5 handshakes
      start_load();
      for (int i = 0; i < 5; i++) issue(1'b1, {16'(16'h3000 + i), 16'(i)}, 1'b0, '0, '0, hs);
      clr_start   = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hFFFF_FFFF;
      tick();
      clr_start   = 1'b0;
      bus.s_valid = 1'b0;
      in_load     = 1'b0;
      zero_model();
      wait_clear(n);
      check("abort_clear_len", 64'(n), 64'd9);
      check("abort_loaded", {63'd0, loaded}, 64'd0);
      read_all();

      // clear and load together from IDLE: clear wins
      clr_start  = 1'b1;
      load_start = 1'b1;
      tick();
      clr_start  = 1'b0;
      load_start = 1'b0;
      check("both_busy",   {63'd0, busy},        64'd1);
      check("both_sready", {63'd0, bus.s_ready}, 64'd0);
      wait_clear(n);
      check("both_clear_len", 64'(n), 64'd9);

      // read-first collision and out-of-range read during LOAD
      start_load();
      for (int i = 0; i < 3; i++) issue(1'b1, {16'(16'h4000 + i), 16'(i)}, 1'b0, '0, '0, hs);
      issue(1'b1, 32'hBEEF_BEEF, 1'b1, 4'd3, 32'h0, hs);
      issue(1'b1, 32'h4004_0004, 1'b1, 4'd12, 32'h0, hs);
      issue(1'b1, 32'h4005_0005, 1'b1, 4'd3, 32'hBEEF_BEEF, hs);

      // reset mid-load at wptr 6
      rst_n       = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = 32'h7777_7777;
      bus.rd_en   = 1'b1;
      bus.raddr   = 4'd3;
      tick();
      rst_n       = 1'b1;
      bus.s_valid = 1'b0;
      bus.rd_en   = 1'b0;
      in_load     = 1'b0;
      zero_model();
      check("mid_rst_sready", {63'd0, bus.s_ready}, 64'd0);
      check("mid_rst_rdata",  {32'd0, bus.rdata},   64'd0);
      check("mid_rst_busy",   {63'd0, busy},        64'd1);
      check("mid_rst_loaded", {63'd0, loaded},      64'd0);
      wait_clear(n);
      check("mid_rst_clear_len", 64'(n), 64'd9);
      read_all();
      start_load();
      for (int i = 0; i < DEPTH; i++) issue(1'b1, {16'(16'h5000 + i), 16'(16'h0A00 + i)}, 1'b0, '0, '0, hs);
      check("reload_loaded", {63'd0, loaded}, 64'd1);
      read_all();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
